// File: rtl/multi_channel_clock_divider.sv
// NUM_CH independent 50%-duty clock dividers with per-channel tick strobes and shadowed divisors.
// Define CLKDIV_IMMEDIATE_LOAD_EN to make a divisor load restart that channel's period at once.
module multi_channel_clock_divider #(
  parameter int              CNT_W       = 32,
  parameter int              NUM_CH      = 4,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(25000000)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              div_load,
  input  logic [3:0]        div_ch,
  input  logic [CNT_W-1:0]  div_value,
  input  logic              sync_clear,
  output logic [NUM_CH-1:0] clock_div,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0][CNT_W-1:0] r_cnt;
  logic [NUM_CH-1:0][CNT_W-1:0] r_act;
  logic [NUM_CH-1:0][CNT_W-1:0] r_shd;
  logic [NUM_CH-1:0]            r_clk_div;
  logic [NUM_CH-1:0]            r_tick;

  logic [NUM_CH-1:0][CNT_W-1:0] w_cnt_nxt;
  logic [NUM_CH-1:0][CNT_W-1:0] w_act_nxt;
  logic [NUM_CH-1:0][CNT_W-1:0] w_shd_nxt;
  logic [NUM_CH-1:0]            w_clk_div_nxt;
  logic [NUM_CH-1:0]            w_tick_nxt;
  logic [NUM_CH-1:0]            w_load_hit;
  logic [NUM_CH-1:0]            w_wrap;

  // div_load is a fire-and-forget strobe: sampled on one edge, no valid/ready or ack,
  // accepted every cycle; an out-of-range div_ch matches no channel and is dropped.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_load_hit[i] = div_load && (div_ch == 4'(i));
      // >= rather than == so a divisor lowered below the count wraps next cycle
      w_wrap[i]     = (r_cnt[i] >= r_act[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_cnt_nxt[i]     = r_cnt[i];
      w_act_nxt[i]     = r_act[i];
      w_shd_nxt[i]     = w_load_hit[i] ? div_value : r_shd[i];
      w_clk_div_nxt[i] = r_clk_div[i];
      w_tick_nxt[i]    = 1'b0;

      if (sync_clear) begin
        w_cnt_nxt[i]     = '0;
        w_clk_div_nxt[i] = 1'b0;
      end else if (!enable) begin
        // keep act tracking shd so a divisor loaded while paused is live on resume
        w_act_nxt[i] = r_shd[i];
      end else if (w_wrap[i]) begin
        w_cnt_nxt[i]     = '0;
        w_clk_div_nxt[i] = ~r_clk_div[i];
        w_tick_nxt[i]    = 1'b1;
        w_act_nxt[i]     = w_load_hit[i] ? div_value : r_shd[i];
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
      end

`ifdef CLKDIV_IMMEDIATE_LOAD_EN
      // restart the period now; output level is held, so one phase may be short
      if (!sync_clear && w_load_hit[i]) begin
        w_cnt_nxt[i]     = '0;
        w_act_nxt[i]     = div_value;
        w_clk_div_nxt[i] = r_clk_div[i];
        w_tick_nxt[i]    = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i] <= '0;
        r_act[i] <= DEFAULT_DIV;
        r_shd[i] <= DEFAULT_DIV;
      end
      r_clk_div <= '0;
      r_tick    <= '0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_act     <= w_act_nxt;
      r_shd     <= w_shd_nxt;
      r_clk_div <= w_clk_div_nxt;
      r_tick    <= w_tick_nxt;
    end
  end

  assign clock_div = r_clk_div;
  assign tick      = r_tick;

endmodule

// File: doc/multi_channel_clock_divider.md
# multi_channel_clock_divider

Parametrised, multi-channel successor to the fixed single-output divider. It generates NUM_CH independent 50 %-duty divided clocks from the system clock, each with a run-time-programmable terminal count. Each channel also produces a one-cycle strobe whenever its output toggles. The block sits between the board oscillator and the slow display/scan/debounce logic, so each consumer gets its own rate from one instance.

## Interface
- CNT_W, 32, width of the per-channel counter and divisor
- NUM_CH, 4, number of independent output channels (1..16)
- DEFAULT_DIV, 25000000, terminal count loaded into every channel at reset
- clk  input  1  system clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-low reset
- enable  input  1  global run; when low, all counters and outputs hold
- div_load  input  1  one-cycle request to program one channel's divisor
- div_ch  input  4  channel index for div_load; indices >= NUM_CH are ignored
- div_value  input  CNT_W  new terminal count N
- sync_clear  input  1  zero every counter and drive every clock_div low
- clock_div  output  NUM_CH  divided clocks, one bit per channel
- tick  output  NUM_CH  one-cycle pulse per channel on each clock_div toggle

## Operation
- Per channel i: counter cnt[i], active divisor act[i], shadow divisor shd[i], output clock_div[i].
- Reset: cnt = 0, act = shd = DEFAULT_DIV, clock_div = 0, tick = 0.
- Run (enable = 1, sync_clear = 0):
  - If cnt[i] >= act[i] (wrap): cnt[i] <= 0, clock_div[i] toggles, tick[i] = 1 for that cycle, act[i] <= shd[i].
  - Otherwise: cnt[i] increments, tick[i] = 0.
  - The compare is >=, not ==. A divisor lowered below the current count wraps on the next cycle instead of running to 2^CNT_W.
- Output period is 2·(N+1) clk cycles, high time N+1. N = 0 gives a clk/2 output.
- div_load with div_ch < NUM_CH: shd[div_ch] <= div_value. The new value becomes active at that channel's next wrap, so the output never glitches. Other channels are unaffected.
- div_load coinciding with a wrap on the same channel: act <= div_value directly. The new value governs the period starting in that cycle.
- Paused (enable = 0): cnt and clock_div hold, tick = 0. Loads still write shd, and act <= shd each paused cycle, so a new divisor is fully in effect on resume.
- sync_clear = 1 (has priority over enable and wrap): all cnt <= 0, clock_div <= 0, tick = 0. act and shd are retained. Use it to phase-align all channels.
- reset asserted mid-period: immediate return to reset values, including act = DEFAULT_DIV. Programmed divisors are lost.
- Counter arithmetic wraps modulo 2^CNT_W. The >= compare makes overflow unreachable.

## Timing
- All outputs are registered. tick[i] is high in the same cycle that clock_div[i] shows its new value.
- After reset deasserts with enable = 1, the first toggle of channel i happens at the clock edge where cnt reaches act, i.e. on the (N+1)th rising edge. The second toggle follows N+1 edges later.
- div_load is sampled on one edge; shd is visible the following cycle. There is no handshake or ack, and back-to-back loads to any channels are accepted every cycle.
- sync_clear: outputs are low and counters are 0 the cycle after it is sampled high. Counting resumes on the edge after it drops.

## Configuration
- CLKDIV_IMMEDIATE_LOAD_EN defined: a valid div_load also sets cnt[div_ch] <= 0 and act[div_ch] <= div_value in the same edge, restarting the period at once. clock_div keeps its current level, which may produce one shortened phase.
- Undefined (default): glitch-free shadow loading exactly as described under Operation.

## Test plan
- Reset, NUM_CH = 2, DEFAULT_DIV = 3, enable = 1 -> each clock_div has period 8 and high time 4; tick pulses every 4 cycles; all outputs 0 during reset.
- div_load ch 1 with value 0 mid-period -> ch 1 completes its current half-period at N = 3, then toggles every cycle (period 2); ch 0 is unchanged.
- Load ch 0 with value 1 while cnt[0] = 2 and act = 5 -> wrap occurs when cnt reaches 5; after that, toggles every 2 cycles. With CLKDIV_IMMEDIATE_LOAD_EN: cnt resets and the toggle occurs 2 cycles after the load.
- enable low for 10 cycles with a load of 7 during the pause -> outputs and counts frozen, tick = 0; after resume the remaining half-period uses N = 7.
- sync_clear pulse with channels out of phase -> all clock_div are 0 the next cycle, then the channels toggle simultaneously when their divisors are equal.
- div_ch = NUM_CH with div_load -> no channel changes; reset asserted mid-count -> immediate zero outputs and act back to DEFAULT_DIV.
